// File: rtl/spi_slave.sv
// SPI mode-0 LSB-first responder with synchronized sclk/cs_n/mosi; SPI_SLAVE_MISO_OE_EN adds the miso_oe port.
// Latency: rx_valid SYNC_STAGES+2 clk after the raw final sclk rise; miso follows a raw sclk fall by SYNC_STAGES+1 clk.
// Backpressure: none; rx_data is overwritten every frame and an empty tx buffer sends zeros with a tx_underrun pulse.
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
`ifdef SPI_SLAVE_MISO_OE_EN
    output logic                  miso_oe,
`endif
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_empty,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_dly, cs_dly;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall;
    logic [CW-1:0]          bit_cnt;
    logic [DATA_WIDTH-1:0]  shift_in, shift_out, tx_buf, frame_byte, shift_next;
    logic                   rx_pend, miso_q, consume;

    assign sclk_s     = sclk_sync[SYNC_STAGES-1];
    assign cs_s       = cs_sync[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise  = sclk_s & ~sclk_dly;
    assign sclk_fall  = ~sclk_s & sclk_dly;
    assign cs_fall    = ~cs_s & cs_dly;
    assign frame_byte = tx_empty ? '0 : tx_buf;
    assign shift_next = {mosi_s, shift_in[DATA_WIDTH-1:1]};

    // A buffer is consumed at frame start and at every frame boundary while cs_n stays low
    assign consume = ((state == IDLE) && cs_fall) ||
                     ((state == SHIFT) && !cs_s && sclk_fall && (bit_cnt == '0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_dly  <= 1'b0;
            cs_dly    <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_dly  <= sclk_s;
            cs_dly    <= cs_s;
        end
    end

    // tx_load wins over a same-cycle consume so freshly loaded data survives for the next frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_buf   <= '0;
            tx_empty <= 1'b1;
        end else if (tx_load) begin
            tx_buf   <= tx_data;
            tx_empty <= 1'b0;
        end else if (consume) begin
            tx_empty <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            bit_cnt     <= '0;
            shift_in    <= '0;
            shift_out   <= '0;
            miso_q      <= 1'b0;
            rx_data     <= '0;
            rx_pend     <= 1'b0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            rx_pend     <= 1'b0;
            rx_valid    <= rx_pend;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state       <= SHIFT;
                        busy        <= 1'b1;
                        bit_cnt     <= '0;
                        shift_out   <= frame_byte;
                        miso_q      <= frame_byte[0];
                        tx_underrun <= tx_empty;
                    end
                end
                SHIFT: begin
                    if (cs_s) begin
                        // partial frames are dropped without touching rx_data
                        state   <= IDLE;
                        busy    <= 1'b0;
                        bit_cnt <= '0;
                        miso_q  <= 1'b0;
                    end else if (sclk_rise) begin
                        shift_in <= shift_next;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            rx_data <= shift_next;
                            rx_pend <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt != '0) begin
                            shift_out <= shift_out >> 1;
                            miso_q    <= shift_out[1];
                        end else begin
                            shift_out   <= frame_byte;
                            miso_q      <= frame_byte[0];
                            tx_underrun <= tx_empty;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_SLAVE_MISO_OE_EN
    assign miso    = miso_q;
    assign miso_oe = busy;
`else
    assign miso    = miso_q & busy;
`endif

endmodule
